// File: rtl/adc_pkg.sv
// Shared defaults and FSM encoding for the ADC burst averager.
package adc_pkg;

  localparam int unsigned DefSampleW = 12;
  localparam int unsigned DefLog2N   = 7;

  typedef enum logic {
    StIdle,
    StAccum
  } avg_state_e;

endpackage

// File: rtl/adc_burst_averager_if.sv
// Sample input, result output and status bundle between the ADC front end and the averager.
interface adc_burst_averager_if import adc_pkg::*; #(
  parameter int unsigned SAMPLE_W = DefSampleW
) ();

  logic                burst_start;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] pdata1;
  logic [SAMPLE_W-1:0] pdata2;
  logic [SAMPLE_W-1:0] avg1;
  logic [SAMPLE_W-1:0] avg2;
  logic [SAMPLE_W:0]   diff;
  logic                result_valid;
  logic                result_ready;
  logic                busy;
  logic                overrun;

  // Producer/consumer side: drives samples and accepts results.
  modport master (
    output burst_start, sample_valid, pdata1, pdata2, result_ready,
    input  avg1, avg2, diff, result_valid, busy, overrun
  );

  // Averager side.
  modport slave (
    input  burst_start, sample_valid, pdata1, pdata2, result_ready,
    output avg1, avg2, diff, result_valid, busy, overrun
  );

endinterface

// File: rtl/channel_accumulator.sv
// One channel's burst accumulator; avg_o is the truncated average of the sum including the
// sample currently presented, so the top can capture it on the final sample's edge.
module channel_accumulator #(
  parameter int unsigned SampleW = 12,
  parameter int unsigned Log2N   = 7
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [SampleW-1:0] sample_i,
  output logic [SampleW-1:0] avg_o
);

  localparam int unsigned AccW = SampleW + Log2N;

  logic [AccW-1:0] acc_q, acc_d, sum_incl;

  assign sum_incl = acc_q + {{Log2N{1'b0}}, sample_i};
  assign avg_o    = sum_incl[AccW-1:Log2N];

  // Next sum: clear wins over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum_incl;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/adc_burst_averager.sv
// Burst averager: accumulates 2^LOG2_N sample pairs per burst and presents per-channel
// averages plus their signed difference through a valid/ready result register.
module adc_burst_averager import adc_pkg::*; #(
  parameter int unsigned SAMPLE_W = DefSampleW,
  parameter int unsigned LOG2_N   = DefLog2N
) (
  input logic                   clk_20M,
  input logic                   reset,
  adc_burst_averager_if.slave   bus
);

  localparam logic [LOG2_N-1:0] CntOne = {{(LOG2_N-1){1'b0}}, 1'b1};

  avg_state_e          state_q, state_d;
  logic [LOG2_N-1:0]   cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] avg1_q, avg1_d, avg2_q, avg2_d;
  logic [SAMPLE_W:0]   diff_q, diff_d;
  logic                rv_q, rv_d;
  logic                ovr_q, ovr_d;

  logic [SAMPLE_W-1:0] avg1_new, avg2_new;
  logic                sample_take, last_sample;

  // A coincident burst_start discards the sample on that cycle.
  assign sample_take = bus.sample_valid && (state_q == StAccum) && !bus.burst_start;
  assign last_sample = sample_take && (cnt_q == '1);

  channel_accumulator #(
    .SampleW (SAMPLE_W),
    .Log2N   (LOG2_N)
  ) u_acc1 (
    .clk_i    (clk_20M),
    .rst_i    (reset),
    .clr_i    (bus.burst_start),
    .en_i     (sample_take),
    .sample_i (bus.pdata1),
    .avg_o    (avg1_new)
  );

  channel_accumulator #(
    .SampleW (SAMPLE_W),
    .Log2N   (LOG2_N)
  ) u_acc2 (
    .clk_i    (clk_20M),
    .rst_i    (reset),
    .clr_i    (bus.burst_start),
    .en_i     (sample_take),
    .sample_i (bus.pdata2),
    .avg_o    (avg2_new)
  );

  // FSM next state and sample counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.burst_start) begin
          state_d = StAccum;
          cnt_d   = '0;
        end
      end
      StAccum: begin
        if (bus.burst_start) begin
          cnt_d = '0;
        end else if (sample_take) begin
          cnt_d = cnt_q + CntOne;
          if (last_sample) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result registers, handshake and sticky overrun.
  always_comb begin
    avg1_d = avg1_q;
    avg2_d = avg2_q;
    diff_d = diff_q;
    rv_d   = rv_q;
    ovr_d  = ovr_q;
    if (rv_q && bus.result_ready) begin
      rv_d = 1'b0;
    end
    if (last_sample) begin
      avg1_d = avg1_new;
      avg2_d = avg2_new;
      diff_d = {1'b0, avg1_new} - {1'b0, avg2_new};
      rv_d   = 1'b1;
      if (rv_q && !bus.result_ready) begin
        ovr_d = 1'b1;
      end
    end
  end

  // State, counter and result register bank.
  always_ff @(posedge clk_20M or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      avg1_q  <= '0;
      avg2_q  <= '0;
      diff_q  <= '0;
      rv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      avg1_q  <= avg1_d;
      avg2_q  <= avg2_d;
      diff_q  <= diff_d;
      rv_q    <= rv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.avg1         = avg1_q;
  assign bus.avg2         = avg2_q;
  assign bus.diff         = diff_q;
  assign bus.result_valid = rv_q;
  assign bus.busy         = (state_q == StAccum);
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_adc_burst_averager.sv
// Directed bench for adc_burst_averager with hand-computed expectations.
module tb_adc_burst_averager;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  adc_burst_averager_if #(.SAMPLE_W(12)) bus ();

  adc_burst_averager #(
    .SAMPLE_W (12),
    .LOG2_N   (7)
  ) dut (
    .clk_20M (clk),
    .reset   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst();
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
  endtask

  // n back-to-back samples: pdata1 = base1 + i*step1, pdata2 constant.
  task automatic run_samples(input int n, input int base1, input int step1, input int v2);
    for (int i = 0; i < n; i++) begin
      bus.sample_valid = 1'b1;
      bus.pdata1       = 12'(base1 + i * step1);
      bus.pdata2       = 12'(v2);
      tick();
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic accept();
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
  endtask

  initial begin
    n_checks         = 0;
    n_pass           = 0;
    bus.burst_start  = 1'b0;
    bus.sample_valid = 1'b0;
    bus.pdata1       = '0;
    bus.pdata2       = '0;
    bus.result_ready = 1'b0;
    rst              = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset state.
    check("rst_rv",   32'(bus.result_valid), 32'd0);
    check("rst_busy", 32'(bus.busy),         32'd0);
    check("rst_ovr",  32'(bus.overrun),      32'd0);
    check("rst_avg1", 32'(bus.avg1),         32'd0);

    // Constant data, result exactly one cycle after the 128th valid.
    start_burst();
    check("c_busy_up", 32'(bus.busy), 32'd1);
    run_samples(127, 1000, 0, 200);
    check("c_rv_early", 32'(bus.result_valid), 32'd0);
    check("c_busy_mid", 32'(bus.busy),         32'd1);
    run_samples(1, 1000, 0, 200);
    check("c_rv",   32'(bus.result_valid), 32'd1);
    check("c_busy", 32'(bus.busy),         32'd0);
    check("c_avg1", 32'(bus.avg1),         32'd1000);
    check("c_avg2", 32'(bus.avg2),         32'd200);
    check("c_diff", 32'(bus.diff),         32'd800);
    accept();
    check("c_rv_acc", 32'(bus.result_valid), 32'd0);
    check("c_ovr",    32'(bus.overrun),      32'd0);

    // Ramp on channel 1, full scale on channel 2.
    start_burst();
    run_samples(128, 0, 1, 4095);
    check("r_avg1", 32'(bus.avg1), 32'd63);
    check("r_avg2", 32'(bus.avg2), 32'd4095);
    check("r_diff", 32'(bus.diff), 32'h1040);
    accept();

    // Restart after a partial burst.
    start_burst();
    run_samples(50, 9, 0, 9);
    check("s_rv_part", 32'(bus.result_valid), 32'd0);
    start_burst();
    run_samples(127, 7, 0, 7);
    check("s_rv_early", 32'(bus.result_valid), 32'd0);
    run_samples(1, 7, 0, 7);
    check("s_rv",   32'(bus.result_valid), 32'd1);
    check("s_avg1", 32'(bus.avg1),         32'd7);
    check("s_avg2", 32'(bus.avg2),         32'd7);
    check("s_diff", 32'(bus.diff),         32'd0);
    check("s_ovr",  32'(bus.overrun),      32'd0);
    accept();

    // Backpressure: second result overwrites the first.
    start_burst();
    run_samples(128, 100, 0, 100);
    check("b_avg1_first", 32'(bus.avg1), 32'd100);
    check("b_ovr_first",  32'(bus.overrun), 32'd0);
    start_burst();
    run_samples(128, 300, 0, 300);
    check("b_avg1", 32'(bus.avg1),         32'd300);
    check("b_rv",   32'(bus.result_valid), 32'd1);
    check("b_ovr",  32'(bus.overrun),      32'd1);
    accept();
    check("b_rv_acc",  32'(bus.result_valid), 32'd0);
    check("b_ovr_acc", 32'(bus.overrun),      32'd1);

    // Asynchronous reset mid-burst clears outputs without waiting for an edge.
    start_burst();
    run_samples(64, 11, 0, 11);
    rst = 1'b1;
    #2;
    check("x_avg1", 32'(bus.avg1),    32'd0);
    check("x_ovr",  32'(bus.overrun), 32'd0);
    check("x_busy", 32'(bus.busy),    32'd0);
    rst = 1'b0;
    tick();
    run_samples(128, 11, 0, 11);
    check("x_rv_idle",   32'(bus.result_valid), 32'd0);
    check("x_busy_idle", 32'(bus.busy),         32'd0);

    // Coincident sample on the burst_start cycle is dropped.
    bus.burst_start  = 1'b1;
    bus.sample_valid = 1'b1;
    bus.pdata1       = 12'd4095;
    bus.pdata2       = 12'd4095;
    tick();
    bus.burst_start  = 1'b0;
    bus.sample_valid = 1'b0;
    run_samples(127, 5, 0, 5);
    check("k_rv_early", 32'(bus.result_valid), 32'd0);
    run_samples(1, 5, 0, 5);
    check("k_avg1", 32'(bus.avg1), 32'd5);
    check("k_avg2", 32'(bus.avg2), 32'd5);
    check("k_rv",   32'(bus.result_valid), 32'd1);

    // Completion on the same edge as an accept: new result, valid stays, no overrun.
    start_burst();
    run_samples(127, 20, 0, 3);
    bus.result_ready = 1'b1;
    run_samples(1, 20, 0, 3);
    bus.result_ready = 1'b0;
    check("a_rv",   32'(bus.result_valid), 32'd1);
    check("a_avg1", 32'(bus.avg1),         32'd20);
    check("a_diff", 32'(bus.diff),         32'd17);
    check("a_ovr",  32'(bus.overrun),      32'd0);
    accept();
    check("a_rv_acc", 32'(bus.result_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_burst_averager.md
# adc_burst_averager

Downstream consumer of the dual-channel ADC front end: accepts paired 12-bit samples (`pdata1`, `pdata2`) strobed by `sample_valid` and accumulates one burst of 2^LOG2_N sample pairs per `burst_start`. At burst end it outputs per-channel averages and their signed difference (the optical force error term) through a valid/ready handshake. It sits between ADC sampling and the host/control interface, and runs entirely in the `clk_20M` domain.

## Interface
- `SAMPLE_W`, default 12: width of each ADC sample.
- `LOG2_N`, default 7: log2 of samples per burst (128 by default).
- `clk_20M`  in  1  the single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `burst_start`  in  1  single-cycle pulse that starts or restarts a burst.
- `sample_valid`  in  1  single-cycle strobe; `pdata1`/`pdata2` are valid this cycle.
- `pdata1`  in  SAMPLE_W  channel 1 sample, unsigned.
- `pdata2`  in  SAMPLE_W  channel 2 sample, unsigned.
- `avg1`  out  SAMPLE_W  channel 1 burst average.
- `avg2`  out  SAMPLE_W  channel 2 burst average.
- `diff`  out  SAMPLE_W+1  signed result, avg1 − avg2, two's complement.
- `result_valid`  out  1  result registers hold an unconsumed result.
- `result_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high while in ACCUM.
- `overrun`  out  1  sticky flag; set when an unconsumed result is overwritten.

## Operation
- States:
  - IDLE: samples are ignored.
  - ACCUM: samples are accumulated.
- IDLE→ACCUM on `burst_start`. On entry, accumulators and the sample counter are cleared to 0.
- ACCUM, `sample_valid`=1:
  - acc1 += pdata1; acc2 += pdata2; count += 1.
  - Accumulator width is SAMPLE_W+LOG2_N (19 bits by default), so it cannot overflow.
- ACCUM, `sample_valid` on the sample where count = 2^LOG2_N−1 (the last sample):
  - The final sums, including this sample, are loaded into the result registers.
  - The block returns to IDLE.
- Arithmetic:
  - avg = final_sum >> LOG2_N, truncating, with no rounding.
  - diff = zero-extended avg1 − zero-extended avg2, SAMPLE_W+1 bits.
- Result registers are separate from the accumulators, so a new burst may run while a result is pending.
- `burst_start` in ACCUM restarts the burst: the partial sums are discarded and no result is produced.
- `burst_start` and `sample_valid` in the same cycle: `burst_start` wins and that sample is dropped (not counted).
- Completion while `result_valid`=1 and not accepted that cycle:
  - The new result overwrites the old one.
  - `result_valid` stays 1.
  - `overrun` is set.
- Completion in the same cycle as an accept (`result_valid`&`result_ready`):
  - The new result loads.
  - `result_valid` stays 1.
  - No overrun.
- `overrun` clears only on `reset`.
- Reset (asynchronous, at any point including mid-burst):
  - State returns to IDLE.
  - Accumulators and counter are cleared.
  - All outputs (`avg1`, `avg2`, `diff`, `result_valid`, `busy`, `overrun`) go to 0.

## Timing
- `busy` rises on the edge after `burst_start` is sampled. It falls on the edge after the last sample is sampled.
- Latency: `result_valid` and the new `avg1`/`avg2`/`diff` appear on the edge after the last `sample_valid` is sampled (1 cycle).
- Handshake:
  - `result_valid` stays high, with outputs stable, until an edge where `result_valid`&`result_ready` are both 1.
  - It is low after that edge unless a completion occurs on the same edge.
  - `result_ready` is ignored while `result_valid`=0.
- Minimum burst length is 2^LOG2_N cycles; back-to-back `sample_valid` on every cycle is supported.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package `adc_pkg`: SAMPLE_W and LOG2_N defaults, and the state encoding (IDLE, ACCUM).
- Sub-module `channel_accumulator`, instantiated twice:
  - Holds one accumulator with clear and enable.
  - Produces a truncated average output.
- The top level holds the FSM, counter, result registers, diff subtractor, handshake and overrun logic.

## Test plan
- Constant data, pdata1=1000, pdata2=200, 128 valids → avg1=1000, avg2=200, diff=+800. `result_valid` is 1 exactly one cycle after the 128th valid; `busy` is then 0.
- Ramp, pdata1=0..127 and pdata2=4095 constant → sum1=8128, avg1=63; avg2=4095 (sum 524160, no overflow); diff=−4032 (13'h1040).
- Restart: 50 valids, then `burst_start`, then 128 valids of pdata1=pdata2=7 → a single result with avg1=avg2=7, diff=0. No result from the partial burst.
- Backpressure: `result_ready`=0, two complete bursts (values 100, then 300) → outputs show 300 and `overrun`=1. Pulse `result_ready` → `result_valid`=0 next cycle; `overrun` stays 1.
- Reset mid-burst after 64 valids → all outputs 0 immediately. Subsequent valids without `burst_start` produce no result and `busy`=0.
- Coincidence: `sample_valid` on the `burst_start` cycle plus 128 further valids of value 5 (first coincident sample = 4095) → avg1=5, proving the coincident sample was dropped. Valids while IDLE are ignored.
